// File: rtl/mac_tc_pkg.sv
// Shared widths and arithmetic helpers for the 16x16 -> 40-bit signed MAC.
package mac_tc_pkg;

    localparam int PROD_W    = 32;  // full width of a 16x16 signed product
    localparam int ACC_W_DEF = 40;  // default accumulator / result width
    localparam int CNT_W_DEF = 9;   // default beat-counter width

    // Signed-add overflow: both operands share a sign and the result does not.
    function automatic logic add_ovf(input logic a_sign, input logic b_sign, input logic s_sign);
        return (a_sign == b_sign) && (s_sign != a_sign);
    endfunction

endpackage

// File: rtl/mul_tc_16_16.sv
// Combinational 16x16 two's-complement multiplier with a full 32-bit product.
module mul_tc_16_16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [31:0] p
);

    // Full-precision signed product; 32 bits can never overflow for 16x16 inputs.
    assign p = $signed(a) * $signed(b);

endmodule

// File: rtl/mac_tc_16_40.sv
// Streaming signed dot-product engine: a registered product stage (P) feeds an
// accumulate stage (A) that emits one result per vector through a
// valid/ready output register with backpressure.
module mac_tc_16_40
    import mac_tc_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [15:0]      a,
    input  logic [15:0]      b,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic [CNT_W-1:0] cnt_out,
    output logic             ovf_out,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [PROD_W-1:0] prod_w;

    logic [PROD_W-1:0] prod_q, prod_d;
    logic              p_valid_q, p_valid_d;
    logic              p_last_q, p_last_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              first_q, first_d;
    logic [ACC_W-1:0]  acc_out_q, acc_out_d;
    logic [CNT_W-1:0]  cnt_out_q, cnt_out_d;
    logic              ovf_out_q, ovf_out_d;
    logic              out_valid_q, out_valid_d;

    logic              stall;
    logic              accept;
    logic              advance;
    logic              load;
    logic [ACC_W-1:0]  prod_ext;
    logic [ACC_W-1:0]  base;
    logic [ACC_W-1:0]  sum;
    logic [CNT_W-1:0]  cnt_next;
    logic              ovf_next;

    mul_tc_16_16 u_mul (
        .a (a),
        .b (b),
        .p (prod_w)
    );

    // Pipeline control, stage P/A next-state and output-register next-state.
    always_comb begin
        // A finished vector waiting behind an unconsumed result freezes both stages.
        stall    = p_valid_q && p_last_q && out_valid_q && !out_ready;
        in_ready = !stall;
        accept   = in_valid && !stall;
        advance  = p_valid_q && !stall;
        load     = advance && p_last_q;

        prod_d    = prod_q;
        p_valid_d = p_valid_q;
        p_last_d  = p_last_q;
        if (accept) begin
            prod_d    = prod_w;
            p_valid_d = 1'b1;
            p_last_d  = in_last;
        end else if (!stall) begin
            p_valid_d = 1'b0;
        end

        prod_ext = {{(ACC_W-PROD_W){prod_q[PROD_W-1]}}, prod_q};
        base     = first_q ? '0 : acc_q;
        sum      = base + prod_ext;
        cnt_next = first_q ? CNT_ONE : ((count_q == CNT_MAX) ? count_q : count_q + CNT_ONE);
        ovf_next = (first_q ? 1'b0 : ovf_q) |
                   add_ovf(base[ACC_W-1], prod_ext[ACC_W-1], sum[ACC_W-1]);

        acc_d   = advance ? sum      : acc_q;
        count_d = advance ? cnt_next : count_q;
        ovf_d   = advance ? ovf_next : ovf_q;
        first_d = advance ? p_last_q : first_q;

        acc_out_d   = load ? sum      : acc_out_q;
        cnt_out_d   = load ? cnt_next : cnt_out_q;
        ovf_out_d   = load ? ovf_next : ovf_out_q;
        out_valid_d = load ? 1'b1 : (out_ready ? 1'b0 : out_valid_q);
    end

    // State registers; reset drops any partial vector and arms a fresh one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_q      <= '0;
            p_valid_q   <= 1'b0;
            p_last_q    <= 1'b0;
            acc_q       <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            first_q     <= 1'b1;
            acc_out_q   <= '0;
            cnt_out_q   <= '0;
            ovf_out_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            prod_q      <= prod_d;
            p_valid_q   <= p_valid_d;
            p_last_q    <= p_last_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
            first_q     <= first_d;
            acc_out_q   <= acc_out_d;
            cnt_out_q   <= cnt_out_d;
            ovf_out_q   <= ovf_out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign acc_out   = acc_out_q;
    assign cnt_out   = cnt_out_q;
    assign ovf_out   = ovf_out_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mac_tc_16_40.sv
// Directed bench for mac_tc_16_40: reset, latency, dot products, backpressure,
// counter saturation with overflow, and reset in the middle of a vector.
module tb_mac_tc_16_40;

    logic        clk;
    logic        rst_n;
    logic [15:0] a;
    logic [15:0] b;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [39:0] acc_out;
    logic [8:0]  cnt_out;
    logic        ovf_out;
    logic        out_valid;
    logic        out_ready;

    int n_cmp = 0;
    int n_err = 0;

    mac_tc_16_40 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .acc_out   (acc_out),
        .cnt_out   (cnt_out),
        .ovf_out   (ovf_out),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one beat and hold it until it is taken (bounded).
    task automatic send_beat(input logic [15:0] av, input logic [15:0] bv, input logic lv);
        logic rdy;
        logic taken;
        a        = av;
        b        = bv;
        in_last  = lv;
        in_valid = 1'b1;
        taken    = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            rdy = in_ready;
            step();
            if (rdy) begin
                taken = 1'b1;
                break;
            end
        end
        if (!taken) check_val("beat_accept_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Wait (bounded) for out_valid; returns with outputs sampled just after the edge.
    task automatic wait_result(input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        if (!seen) check_val({tag, "_timeout"}, 64'd0, 64'd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        a         = '0;
        b         = '0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;

        // Reset state
        #12;
        check_val("rst_out_valid", 64'(out_valid), 64'd0);
        check_val("rst_acc_out",   64'(acc_out),   64'd0);
        check_val("rst_cnt_out",   64'(cnt_out),   64'd0);
        check_val("rst_ovf_out",   64'(ovf_out),   64'd0);
        check_val("rst_in_ready",  64'(in_ready),  64'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        check_val("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Single beat -8000h * -8000h: latency of two edges from drive
        a = 16'h8000; b = 16'h8000; in_last = 1'b1; in_valid = 1'b1;
        step();                       // captured into stage P
        in_valid = 1'b0; in_last = 1'b0;
        check_val("single_lat_t1_valid", 64'(out_valid), 64'd0);
        step();                       // result register loads
        check_val("single_valid", 64'(out_valid), 64'd1);
        check_val("single_acc",   64'(acc_out),   64'h0040000000);
        check_val("single_cnt",   64'(cnt_out),   64'd1);
        check_val("single_ovf",   64'(ovf_out),   64'd0);
        step();
        check_val("single_consumed", 64'(out_valid), 64'd0);

        // Three-beat vector: 12 - 30 - 56 = -74
        send_beat(16'd3, 16'd4, 1'b0);
        send_beat(-16'sd5, 16'd6, 1'b0);
        send_beat(16'd7, -16'sd8, 1'b1);
        wait_result("dot3");
        check_val("dot3_acc", 64'(acc_out), 64'hFFFFFFFFB6);
        check_val("dot3_cnt", 64'(cnt_out), 64'd3);
        check_val("dot3_ovf", 64'(ovf_out), 64'd0);
        step();

        // Backpressure: (1,1) then (2,2) back-to-back with out_ready low
        out_ready = 1'b0;
        a = 16'd1; b = 16'd1; in_last = 1'b1; in_valid = 1'b1;
        step();
        a = 16'd2; b = 16'd2;
        step();
        in_valid = 1'b0; in_last = 1'b0;
        check_val("bp_first_valid", 64'(out_valid), 64'd1);
        check_val("bp_first_acc",   64'(acc_out),   64'd1);
        check_val("bp_in_ready_low", 64'(in_ready), 64'd0);
        step();
        step();
        check_val("bp_hold_acc",   64'(acc_out),  64'd1);
        check_val("bp_hold_cnt",   64'(cnt_out),  64'd1);
        check_val("bp_hold_ready", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        #1;
        check_val("bp_release_ready", 64'(in_ready), 64'd1);
        step();
        check_val("bp_second_valid", 64'(out_valid), 64'd1);
        check_val("bp_second_acc",   64'(acc_out),   64'd4);
        step();
        check_val("bp_no_dup", 64'(out_valid), 64'd0);

        // Overflow and count saturation: 600 x 2^30 wraps past 2^39
        for (int i = 1; i <= 600; i++) begin
            send_beat(16'h8000, 16'h8000, (i == 600));
        end
        wait_result("ovf");
        check_val("ovf_flag", 64'(ovf_out), 64'd1);
        check_val("ovf_cnt",  64'(cnt_out), 64'd511);
        check_val("ovf_acc",  64'(acc_out), 64'h9600000000);
        step();

        // Next vector starts its overflow flag afresh
        send_beat(16'd1, 16'd1, 1'b1);
        wait_result("fresh");
        check_val("fresh_ovf", 64'(ovf_out), 64'd0);
        check_val("fresh_cnt", 64'(cnt_out), 64'd1);
        check_val("fresh_acc", 64'(acc_out), 64'd1);
        step();

        // Reset mid-vector discards the partial sum
        send_beat(16'd1, 16'd1, 1'b0);
        send_beat(16'd1, 16'd1, 1'b0);
        rst_n = 1'b0;
        #3;
        check_val("midrst_in_ready",  64'(in_ready),  64'd1);
        check_val("midrst_out_valid", 64'(out_valid), 64'd0);
        step();
        rst_n = 1'b1;
        step();
        send_beat(16'd2, 16'd3, 1'b1);
        wait_result("midrst");
        check_val("midrst_acc", 64'(acc_out), 64'd6);
        check_val("midrst_cnt", 64'(cnt_out), 64'd1);
        check_val("midrst_ovf", 64'(ovf_out), 64'd0);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mac_tc_16_40.md
MAC_TC_16_40 -- requirements
Module: mac_tc_16_40

Interface
REQ-001 SHALL have parameter ACC_W, default 40: accumulator and result width in bits.
REQ-002 SHALL have parameter CNT_W, default 9: beat-counter width in bits.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port a, input, 16: two's-complement multiplicand.
REQ-006 SHALL have port b, input, 16: two's-complement multiplier.
REQ-007 SHALL have port in_valid, input, 1: a, b and in_last are valid.
REQ-008 SHALL have port in_last, input, 1: this beat ends the current vector.
REQ-009 SHALL have port in_ready, output, 1: beat is accepted when in_valid && in_ready.
REQ-010 SHALL have port acc_out, output, ACC_W: signed dot-product result.
REQ-011 SHALL have port cnt_out, output, CNT_W: number of beats in the result vector.
REQ-012 SHALL have port ovf_out, output, 1: signed overflow occurred somewhere in the vector.
REQ-013 SHALL have port out_valid, output, 1: result outputs are valid.
REQ-014 SHALL have port out_ready, input, 1: result is consumed when out_valid && out_ready.

Function
REQ-015 SHALL have stage P: on accept, register prod = a*b (32-bit signed), p_valid=1 and p_last=in_last; clear p_valid when there is no accept and stage P is not stalled.
REQ-016 SHALL have stage A: when p_valid and not stalled, compute sum = (first ? 0 : acc) + sign-extended prod, then set acc <= sum and first <= p_last.
REQ-017 SHALL increment the beat count per stage-A beat, saturating at 2^CNT_W-1; the first beat of a vector loads 1.
REQ-018 SHALL set ovf per vector, sticky, on signed overflow of the ACC_W add (operand signs equal, result sign differs); acc wraps; the first beat of a vector re-evaluates ovf from scratch.
REQ-019 SHALL, on a p_last beat with no stall, load acc_out=sum, cnt_out=count, ovf_out=ovf and set out_valid=1.
REQ-020 SHALL define stall = p_valid && p_last && out_valid && !out_ready; while stalled, stage P and stage A hold.
REQ-021 SHALL drive in_ready = !stall (combinational).
REQ-022 SHALL update out_valid as: next = load ? 1 : (out_ready ? 0 : out_valid); a same-cycle consume plus load leaves out_valid=1 with the new data.
REQ-023 SHALL hold acc_out, cnt_out and ovf_out stable while out_valid && !out_ready.
REQ-024 SHALL have latency: a last beat accepted at edge t gives out_valid at edge t+2.
REQ-025 SHALL sustain a throughput of 1 beat/cycle absent stall.
REQ-026 SHALL treat a single beat with in_last=1 as a one-beat vector.

Reset
REQ-027 SHALL, on rst_n=0, immediately clear p_valid, p_last, acc, count, ovf, acc_out, cnt_out, ovf_out and out_valid to 0, and set first=1.
REQ-028 SHALL have in_ready=1 during and after reset.
REQ-029 SHALL discard any partial vector when reset is asserted mid-operation; the first beat after release starts a new vector.

Structure
REQ-030 SHALL place PROD_W=32, ACC_W default and CNT_W default in shared package mac_tc_pkg.
REQ-031 SHALL instantiate the existing combinational mul_tc_16_16 as the sole sub-module for the product; no other arithmetic sub-modules.

Verification
REQ-032 SHALL check reset: after rst_n=0, out_valid=0, acc_out=0, cnt_out=0, ovf_out=0 and in_ready=1.
REQ-033 SHALL check a single beat a=16'h8000, b=16'h8000, last=1 at edge t -> at t+2, out_valid=1, acc_out=40'h0040000000, cnt_out=1, ovf_out=0.
REQ-034 SHALL check a 3-beat vector (3,4), (-5,6), (7,-8), last on the 3rd beat -> acc_out=40'hFFFFFFFFB6 (-74), cnt_out=3.
REQ-035 SHALL check backpressure: out_ready=0 with back-to-back single-beat vectors (1,1) then (2,2) -> first result (1) is held, then in_ready falls; on out_ready=1, result 4 follows with no loss or duplication.
REQ-036 SHALL check overflow: 600 beats of (16'h8000, 16'h8000) with last on beat 600 -> ovf_out=1, cnt_out=511 (saturated).
REQ-037 SHALL check reset mid-vector: after 2 beats of (1,1), pulse rst_n, then send (2,3) last -> acc_out=6, cnt_out=1.
